// File: rtl/switch_tick_front_end.sv
// Purpose: builds the game step tick from CLOCK and turns four bouncing slide switches into clean levels and per-tick rise events.
// Latency: 2-flop sync plus DEBOUNCE_CYCLES to SW_STABLE; EVT/EVT_MULTI/EVT_VALID are registered one cycle after TICK.
// Backpressure: none; events are strobed once per tick window and the consumer must take them while EVT_VALID is high.
module switch_tick_front_end #(
  parameter int TICK_DIV        = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [3:0] SWITCHES,
  input  logic       HOLD,
  output logic       TICK,
  output logic [3:0] SW_STABLE,
  output logic       EVT_VALID,
  output logic [3:0] EVT,
  output logic [3:0] EVT_MULTI
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  // Synchronizer stages for the asynchronous switch inputs.
  logic [3:0] s1;
  logic [3:0] s2;

  // Per-switch debounce counters and their decodes.
  logic [CW-1:0] cnt [4];
  logic [3:0]    differ;
  logic [3:0]    accept;
  logic [3:0]    rise;

  // Prescaler state.
  logic [DW-1:0] div_cnt;
  logic          div_last;

  // Events accumulated over the open tick window.
  logic [3:0] pend;
  logic [3:0] multi;

  // Two-flop synchronizer: s1 may go metastable, s2 is the first trusted sample.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= SWITCHES;
      s2 <= s1;
    end
  end

  // Decode which switches disagree with their stable level and which disagreements are accepted now.
  always_comb begin
    differ = '0;
    accept = '0;
    for (int i = 0; i < 4; i++) begin
      differ[i] = (s2[i] != SW_STABLE[i]);
      accept[i] = differ[i] && (cnt[i] == CNT_LAST);
    end
  end

  // An accepted change on a switch whose stable level is 0 is a 0->1 transition; falls are dropped.
  assign rise = accept & ~SW_STABLE;

  // Debounce: a change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      SW_STABLE <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!differ[i]) begin
          // any agreeing sample restarts the run
          cnt[i] <= '0;
        end else if (accept[i]) begin
          SW_STABLE[i] <= s2[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // TICK is a pure decode of registered state, gated by HOLD so a frozen prescaler never strobes.
  assign div_last = (div_cnt == DIV_LAST);
  assign TICK     = div_last && !HOLD;

  // Prescaler: free-running modulo-TICK_DIV counter that stands still while HOLD is high.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      div_cnt <= '0;
    end else if (!HOLD) begin
      if (div_last) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Window accumulation: a rise on the closing edge is folded into the window being reported,
  // so it is neither lost nor carried into the next window.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      pend      <= '0;
      multi     <= '0;
      EVT       <= '0;
      EVT_MULTI <= '0;
      EVT_VALID <= 1'b0;
    end else if (TICK) begin
      EVT       <= pend | rise;
      EVT_MULTI <= multi | (rise & pend);
      pend      <= '0;
      multi     <= '0;
      EVT_VALID <= 1'b1;
    end else begin
      pend      <= pend | rise;
      multi     <= multi | (rise & pend);
      EVT_VALID <= 1'b0;
    end
  end

endmodule
